// File: rtl/poly_pkg.sv
// Shared types and size helpers for the Falcon trim_i8 private-key encoder.
package poly_pkg;

  typedef logic signed [7:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PACK,
    ST_FIN
  } state_t;

  function automatic int fg_bits(input int logn);
    return (logn == 9) ? 6 : 5;
  endfunction

  function automatic int fg_nbytes(input int logn);
    return ((1 << logn) * fg_bits(logn)) / 8;
  endfunction

endpackage

// File: rtl/trim_bit_packer.sv
// MSB-first bit accumulator that turns BITS-wide coefficient fields into a
// valid/ready byte stream; a new byte may load in the same cycle the old one is taken.
module trim_bit_packer #(
  parameter int BITS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_active,
  input  logic            i_have,
  input  logic [BITS-1:0] i_bits,
  input  logic            i_out_ready,
  output logic            o_take,
  output logic            o_empty,
  output logic            o_out_valid,
  output logic [7:0]      o_out_byte
);

  localparam logic [3:0] BITS_W = 4'(BITS);

  logic [15:0] r_acc;
  logic [3:0]  r_acc_len;
  logic        r_out_valid;
  logic [7:0]  r_out_byte;

  logic [3:0]  w_hi;
  logic        w_emit;

  assign w_hi   = r_acc_len - 4'd1;
  // Emitting a byte has priority; a field is only shifted in when fewer than 8 bits wait.
  assign w_emit = i_active && (r_acc_len >= 4'd8) && (!r_out_valid || i_out_ready);
  assign o_take = i_active && !w_emit && (r_acc_len < 4'd8) && i_have;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_acc_len   <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= '0;
    end else if (w_emit) begin
      r_out_byte  <= r_acc[w_hi -: 8];
      r_out_valid <= 1'b1;
      r_acc_len   <= r_acc_len - 4'd8;
    end else begin
      if (o_take) begin
        r_acc     <= {r_acc[15-BITS:0], i_bits};
        r_acc_len <= r_acc_len + BITS_W;
      end
      if (i_active && r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_empty     = (r_acc_len == 4'd0) && !r_out_valid;
  assign o_out_valid = r_out_valid;
  assign o_out_byte  = r_out_byte;

endmodule

// File: rtl/poly_trim_i8_encode.sv
// Captures one small polynomial, range-checks every coefficient, then streams
// its trim_i8 encoding (BITS bits per coefficient, MSB-first) as bytes.
module poly_trim_i8_encode
  import poly_pkg::*;
#(
  parameter int logn = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   f_valid,
  input  logic [(1<<logn)*8-1:0] f,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int N    = 1 << logn;
  localparam int BITS = fg_bits(logn);
  localparam int IW   = logn + 1;
  localparam coef_t          LIM      = coef_t'((1 << (BITS - 1)) - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0]  IDX_END  = IW'(N);

  state_t        r_state;
  state_t        w_state_next;
  coef_t         r_buf [N];
  logic [IW-1:0] r_idx;
  logic          r_err;

  coef_t         w_coef;
  logic          w_bad;
  logic          w_accept;
  logic          w_idx_clr;
  logic          w_idx_inc;
  logic          w_err_set;
  logic          w_take;
  logic          w_empty;
  logic          w_active;
  logic          w_have;

  assign w_coef   = r_buf[r_idx[logn-1:0]];
  // -2^(BITS-1) fits the field but is reserved, so the legal range is symmetric.
  assign w_bad    = (w_coef > LIM) || (w_coef < -LIM);
  assign w_active = (r_state == ST_PACK);
  assign w_have   = (r_idx < IDX_END);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_err_set    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (f_valid) begin
          w_accept     = 1'b1;
          w_idx_clr    = 1'b1;
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_bad) begin
          w_err_set    = 1'b1;
          w_state_next = ST_FIN;
        end else if (r_idx == IDX_LAST) begin
          w_idx_clr    = 1'b1;
          w_state_next = ST_PACK;
        end else begin
          w_idx_inc    = 1'b1;
        end
      end
      ST_PACK: begin
        w_idx_inc = w_take;
        if ((r_idx == IDX_END) && w_empty) begin
          w_state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + IW'(1);
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Coefficient store carries no reset; it is always rewritten before being read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < N; j++) begin
        r_buf[j] <= f[(N-j)*8-1 -: 8];
      end
    end
  end

  trim_bit_packer #(
    .BITS(BITS)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_active    (w_active),
    .i_have      (w_have),
    .i_bits      (w_coef[BITS-1:0]),
    .i_out_ready (out_ready),
    .o_take      (w_take),
    .o_empty     (w_empty),
    .o_out_valid (out_valid),
    .o_out_byte  (out_byte)
  );

  assign busy = (r_state == ST_CHECK) || (r_state == ST_PACK);
  assign done = (r_state == ST_FIN);
  assign err  = r_err;

endmodule

// File: tb/tb_poly_trim_i8_encode.sv
// Scoreboard bench for poly_trim_i8_encode at logn 9 and logn 10.
module tb_poly_trim_i8_encode;
  import poly_pkg::*;

  localparam int N9  = 512;
  localparam int N10 = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              fValid9 = 1'b0;
  logic              fValid10 = 1'b0;
  logic [N9*8-1:0]   f9 = '0;
  logic [N10*8-1:0]  f10 = '0;
  logic              outReady9 = 1'b1;
  logic              outReady10 = 1'b1;
  logic              outValid9, outValid10;
  logic [7:0]        outByte9, outByte10;
  logic              busy9, busy10, done9, done10, err9, err10;

  bit   stall9 = 1'b0;
  bit   stall10 = 1'b0;
  int   nChecks = 0;
  int   nPass = 0;
  int   xfer9 = 0;
  int   xfer10 = 0;
  logic [7:0] q9[$];
  logic [7:0] q10[$];
  int   coefs[N10];

  logic [7:0] prevByte9, prevByte10;
  bit   prevStall9 = 1'b0;
  bit   prevStall10 = 1'b0;

  always #5 clk = ~clk;

  poly_trim_i8_encode #(.logn(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .f_valid(fValid9), .f(f9),
    .out_valid(outValid9), .out_ready(outReady9), .out_byte(outByte9),
    .busy(busy9), .done(done9), .err(err9)
  );

  poly_trim_i8_encode #(.logn(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .f_valid(fValid10), .f(f10),
    .out_valid(outValid10), .out_ready(outReady10), .out_byte(outByte10),
    .busy(busy10), .done(done10), .err(err10)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Sink: random backpressure only while a stall run is active.
  initial forever begin
    @(posedge clk);
    #1;
    outReady9  = stall9  ? 1'($urandom_range(0, 1)) : 1'b1;
    outReady10 = stall10 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall9 = 1'b0;
    end else begin
      if (prevStall9) checkOutput("hold9", {outValid9, outByte9}, {1'b1, prevByte9});
      if (outValid9 && outReady9) begin
        xfer9++;
        if (q9.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL extra9: unexpected byte %0d, none expected", outByte9);
        end else begin
          checkOutput("byte9", outByte9, q9.pop_front());
        end
      end
      prevStall9 = outValid9 && !outReady9;
      prevByte9  = outByte9;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall10 = 1'b0;
    end else begin
      if (prevStall10) checkOutput("hold10", {outValid10, outByte10}, {1'b1, prevByte10});
      if (outValid10 && outReady10) begin
        xfer10++;
        if (q10.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL extra10: unexpected byte %0d, none expected", outByte10);
        end else begin
          checkOutput("byte10", outByte10, q10.pop_front());
        end
      end
      prevStall10 = outValid10 && !outReady10;
      prevByte10  = outByte10;
    end
  end

  task automatic setCoefs(input int v);
    for (int j = 0; j < N10; j++) coefs[j] = v;
  endtask

  task automatic pushFill(input int logn, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] rest);
    for (int k = 0; k < fg_nbytes(logn); k++) begin
      logic [7:0] b;
      b = (k == 0) ? b0 : (k == 1) ? b1 : rest;
      if (logn == 9) q9.push_back(b);
      else q10.push_back(b);
    end
  endtask

  // Reference encoder: concatenate BITS-bit two's-complement fields, cut into bytes.
  task automatic pushModel(input int logn);
    int bits, cnt;
    logic [7:0] cur, c;
    bits = fg_bits(logn);
    cnt = 0;
    cur = '0;
    for (int j = 0; j < (1 << logn); j++) begin
      c = 8'(coefs[j]);
      for (int b = bits - 1; b >= 0; b--) begin
        cur = {cur[6:0], c[b]};
        cnt++;
        if (cnt == 8) begin
          if (logn == 9) q9.push_back(cur);
          else q10.push_back(cur);
          cnt = 0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int logn, input bit doStall, output int startX);
    if (logn == 9) begin
      for (int j = 0; j < N9; j++) f9[(N9-j)*8-1 -: 8] = 8'(coefs[j]);
      stall9 = doStall;
      startX = xfer9;
    end else begin
      for (int j = 0; j < N10; j++) f10[(N10-j)*8-1 -: 8] = 8'(coefs[j]);
      stall10 = doStall;
      startX = xfer10;
    end
    @(posedge clk); #1;
    if (logn == 9) fValid9 = 1'b1; else fValid10 = 1'b1;
    @(posedge clk); #1;
    fValid9 = 1'b0;
    fValid10 = 1'b0;
    @(negedge clk);
    checkOutput("busyAfterAccept", (logn == 9) ? busy9 : busy10, 1);
  endtask

  task automatic waitDone(input int logn, input bit expErr, input int startX, input int expX);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      seen = (logn == 9) ? done9 : done10;
    end
    checkOutput("doneSeen", seen, 1);
    if (seen) begin
      checkOutput("errAtDone", (logn == 9) ? err9 : err10, expErr);
      checkOutput("busyAtDone", (logn == 9) ? busy9 : busy10, 0);
      checkOutput("xferCount", ((logn == 9) ? xfer9 : xfer10) - startX, expX);
      checkOutput("queueDrained", (logn == 9) ? q9.size() : q10.size(), 0);
      @(negedge clk);
      checkOutput("donePulse", (logn == 9) ? done9 : done10, 0);
      checkOutput("errHold", (logn == 9) ? err9 : err10, expErr);
    end
    stall9 = 1'b0;
    stall10 = 1'b0;
    q9.delete();
    q10.delete();
  endtask

  task automatic runPoly(input int logn, input bit expErr, input bit doStall);
    int sx;
    applyStimulus(logn, doStall, sx);
    waitDone(logn, expErr, sx, expErr ? 0 : fg_nbytes(logn));
  endtask

  task automatic randomLegal(input int logn);
    int lim;
    lim = (1 << (fg_bits(logn) - 1)) - 1;
    for (int j = 0; j < N10; j++) coefs[j] = int'($urandom_range(0, 2 * lim)) - lim;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sx;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstOutValid", {outValid9, outValid10}, 0);
    checkOutput("rstOutByte", {outByte9, outByte10}, 0);
    checkOutput("rstBusyDoneErr", {busy9, done9, err9, busy10, done10, err10}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] all-zero logn 9");
    setCoefs(0);
    pushFill(9, 8'h00, 8'h00, 8'h00);
    runPoly(9, 1'b0, 1'b0);

    $display("[TB] all -1 logn 9 and 10");
    setCoefs(-1);
    pushFill(9, 8'hFF, 8'hFF, 8'hFF);
    runPoly(9, 1'b0, 1'b0);
    pushFill(10, 8'hFF, 8'hFF, 8'hFF);
    runPoly(10, 1'b0, 1'b0);

    $display("[TB] extreme legal values");
    setCoefs(0);
    coefs[0] = 31;
    coefs[1] = -31;
    pushFill(9, 8'h7E, 8'h10, 8'h00);
    runPoly(9, 1'b0, 1'b0);
    coefs[0] = 15;
    coefs[1] = -15;
    pushFill(10, 8'h7C, 8'h40, 8'h00);
    runPoly(10, 1'b0, 1'b0);

    $display("[TB] illegal coefficients");
    setCoefs(0);
    coefs[5] = -32;
    runPoly(9, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("errStillHeld", err9, 1);
    setCoefs(0);
    coefs[N9-1] = 40;
    runPoly(9, 1'b1, 1'b0);
    setCoefs(0);
    coefs[0] = -16;
    runPoly(10, 1'b1, 1'b0);

    $display("[TB] random legal with backpressure");
    randomLegal(9);
    pushModel(9);
    runPoly(9, 1'b0, 1'b1);
    randomLegal(10);
    pushModel(10);
    runPoly(10, 1'b0, 1'b1);

    $display("[TB] second f_valid during PACK");
    randomLegal(9);
    pushModel(9);
    applyStimulus(9, 1'b1, sx);
    for (int c = 0; c < 5000 && xfer9 < sx + 10; c++) @(negedge clk);
    checkOutput("midStreamReached", xfer9 >= sx + 10, 1);
    f9 = {N9{8'h20}};
    @(posedge clk); #1;
    fValid9 = 1'b1;
    @(posedge clk); #1;
    fValid9 = 1'b0;
    waitDone(9, 1'b0, sx, fg_nbytes(9));

    $display("[TB] reset mid-PACK then fresh polynomial");
    randomLegal(9);
    pushModel(9);
    applyStimulus(9, 1'b1, sx);
    for (int c = 0; c < 5000 && xfer9 < sx + 20; c++) @(negedge clk);
    checkOutput("preResetProgress", xfer9 >= sx + 20, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    stall9 = 1'b0;
    q9.delete();
    @(negedge clk);
    checkOutput("abortOutValid", outValid9, 0);
    checkOutput("abortOutByte", outByte9, 0);
    checkOutput("abortBusyDone", {busy9, done9, err9}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    setCoefs(0);
    coefs[0] = 31;
    coefs[1] = -31;
    pushFill(9, 8'h7E, 8'h10, 8'h00);
    runPoly(9, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
